// File: rtl/operand_deserializer.sv
// operand_deserializer
// Receive side of the operand serial link feeding the matrix-multiply datapath.
// Collects N_ELEM (A,B) element beats, framed by in_first on element 0, into
// packed parallel vectors and presents each finished frame on a valid/ready
// output. Framing violations (resync on a new first marker, orphan beats)
// raise a one-cycle frame_err pulse.
//
// Element k of a frame lands in bits [k*DATA_W +: DATA_W] of out_a/out_b.
// While a completed frame waits for the consumer, the earlier beats of the
// next frame are still accepted; only the completing beat is stalled.

module operand_deserializer #(
  parameter int DATA_W = 8,
  parameter int N_ELEM = 4   // legal range 1..16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_ELEM*DATA_W-1:0] out_a,
  output logic [N_ELEM*DATA_W-1:0] out_b,
  output logic                     frame_err
);

  localparam int IDX_W = $clog2(N_ELEM) + 1;
  localparam int VEC_W = N_ELEM * DATA_W;
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

  // Registered state
  logic [IDX_W-1:0] idx_r;
  logic [VEC_W-1:0] asm_a_r;
  logic [VEC_W-1:0] asm_b_r;
  logic [VEC_W-1:0] out_a_r;
  logic [VEC_W-1:0] out_b_r;
  logic             out_valid_r;
  logic             frame_err_r;

  // Beat classification
  logic at_first_s;
  logic at_last_s;
  logic in_ready_s;
  logic acc_s;
  logic normal_s;
  logic resync_s;
  logic orphan_s;
  logic complete_s;

  // Assembly vectors with the current beat merged in
  logic [VEC_W-1:0] merged_a_s;
  logic [VEC_W-1:0] merged_b_s;
  logic [VEC_W-1:0] restart_a_s;
  logic [VEC_W-1:0] restart_b_s;

  // Next-state values
  logic [IDX_W-1:0] idx_nxt_s;
  logic [VEC_W-1:0] asm_a_nxt_s;
  logic [VEC_W-1:0] asm_b_nxt_s;
  logic [VEC_W-1:0] out_a_nxt_s;
  logic [VEC_W-1:0] out_b_nxt_s;
  logic             out_valid_nxt_s;
  logic             frame_err_nxt_s;

  // Classify the incoming beat; in_ready depends only on registers and out_ready
  always_comb begin
    at_first_s = (idx_r == IDX_ZERO);
    at_last_s  = (idx_r == IDX_LAST);
    // Only the completing beat must wait for the held frame to drain.
    in_ready_s = !(at_last_s && out_valid_r && !out_ready);
    acc_s      = in_valid && in_ready_s;
    // Expected framing: first marker exactly on slot 0.
    normal_s   = acc_s && (in_first == at_first_s);
    resync_s   = acc_s && in_first && !at_first_s;
    orphan_s   = acc_s && !in_first && at_first_s;
    complete_s = normal_s && at_last_s;
  end

  // Build the assembly vector with the current beat written to slot idx, and
  // the restart vector used when a resync beat begins a fresh frame at slot 0
  always_comb begin
    merged_a_s  = asm_a_r;
    merged_b_s  = asm_b_r;
    restart_a_s = asm_a_r;
    restart_b_s = asm_b_r;
    for (int k = 0; k < N_ELEM; k++) begin
      merged_a_s[k*DATA_W +: DATA_W]  = (idx_r == IDX_W'(k)) ? in_a : asm_a_r[k*DATA_W +: DATA_W];
      merged_b_s[k*DATA_W +: DATA_W]  = (idx_r == IDX_W'(k)) ? in_b : asm_b_r[k*DATA_W +: DATA_W];
      restart_a_s[k*DATA_W +: DATA_W] = (k == 0) ? in_a : asm_a_r[k*DATA_W +: DATA_W];
      restart_b_s[k*DATA_W +: DATA_W] = (k == 0) ? in_b : asm_b_r[k*DATA_W +: DATA_W];
    end
  end

  // Next index and assembly contents
  always_comb begin
    idx_nxt_s   = idx_r;
    asm_a_nxt_s = asm_a_r;
    asm_b_nxt_s = asm_b_r;
    if (complete_s) begin
      // Frame handed to the output registers; start the next one at slot 0.
      idx_nxt_s   = IDX_ZERO;
      asm_a_nxt_s = merged_a_s;
      asm_b_nxt_s = merged_b_s;
    end else if (normal_s) begin
      idx_nxt_s   = idx_r + IDX_ONE;
      asm_a_nxt_s = merged_a_s;
      asm_b_nxt_s = merged_b_s;
    end else if (resync_s) begin
      // Partial frame abandoned; the new first beat occupies slot 0.
      idx_nxt_s   = IDX_ONE;
      asm_a_nxt_s = restart_a_s;
      asm_b_nxt_s = restart_b_s;
    end else begin
      // Idle, stalled or orphan beat: nothing in the assembly changes.
      idx_nxt_s   = idx_r;
      asm_a_nxt_s = asm_a_r;
      asm_b_nxt_s = asm_b_r;
    end
  end

  // Next output frame, valid flag and error pulse
  always_comb begin
    out_a_nxt_s     = out_a_r;
    out_b_nxt_s     = out_b_r;
    out_valid_nxt_s = out_valid_r;
    frame_err_nxt_s = resync_s || orphan_s;
    if (complete_s) begin
      // A completing beat is only accepted when the output slot is free or
      // draining this cycle, so loading here never overwrites a held frame.
      out_a_nxt_s     = merged_a_s;
      out_b_nxt_s     = merged_b_s;
      out_valid_nxt_s = 1'b1;
    end else if (out_valid_r && out_ready) begin
      // Drained with nothing new: vectors keep their last value.
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r       <= IDX_ZERO;
      asm_a_r     <= {VEC_W{1'b0}};
      asm_b_r     <= {VEC_W{1'b0}};
      out_a_r     <= {VEC_W{1'b0}};
      out_b_r     <= {VEC_W{1'b0}};
      out_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      idx_r       <= idx_nxt_s;
      asm_a_r     <= asm_a_nxt_s;
      asm_b_r     <= asm_b_nxt_s;
      out_a_r     <= out_a_nxt_s;
      out_b_r     <= out_b_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      frame_err_r <= frame_err_nxt_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_a     = out_a_r;
  assign out_b     = out_b_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_operand_deserializer.sv
// tb_operand_deserializer
// Directed bench for operand_deserializer with DATA_W=8, N_ELEM=4.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.

module tb_operand_deserializer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_first;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        frame_err;

  int n_checks;
  int n_errors;

  operand_deserializer #(.DATA_W(8), .N_ELEM(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .frame_err (frame_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one clock edge
  task automatic beat(input logic f, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_first = f;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] exp_a [3];
  logic [31:0] exp_b [3];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    out_ready = 1'b1;
    exp_a[0] = 32'h43424140; exp_b[0] = 32'hC3C2C1C0;
    exp_a[1] = 32'h53525150; exp_b[1] = 32'hD3D2D1D0;
    exp_a[2] = 32'h63626160; exp_b[2] = 32'hE3E2E1E0;

    // Reset state
    step();
    step();
    reset = 1'b0;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_a",     out_a,          32'h0);
    check("rst_b",     out_b,          32'h0);
    check("rst_err",   32'(frame_err), 32'h0);
    check("rst_ready", 32'(in_ready),  32'h1);

    // Basic frame
    beat(1'b1, 8'h11, 8'h21);
    check("basic_v0", 32'(out_valid), 32'h0);
    beat(1'b0, 8'h12, 8'h22);
    beat(1'b0, 8'h13, 8'h23);
    check("basic_v2", 32'(out_valid), 32'h0);
    beat(1'b0, 8'h14, 8'h24);
    check("basic_valid", 32'(out_valid), 32'h1);
    check("basic_a",     out_a,          32'h14131211);
    check("basic_b",     out_b,          32'h24232221);
    step();
    check("basic_drop", 32'(out_valid), 32'h0);
    check("basic_hold", out_a,          32'h14131211);

    // Back-to-back frames, 12 consecutive beats
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        in_valid = 1'b1;
        in_first = (k == 0);
        in_a     = 8'(8'h40 + 8'(f * 16) + 8'(k));
        in_b     = 8'(8'hC0 + 8'(f * 16) + 8'(k));
        #1;
        check("b2b_ready", 32'(in_ready), 32'h1);
        step();
        if (k == 3) begin
          check("b2b_valid", 32'(out_valid), 32'h1);
          check("b2b_a",     out_a,          exp_a[f]);
          check("b2b_b",     out_b,          exp_b[f]);
        end else begin
          check("b2b_gap", 32'(out_valid), 32'h0);
        end
      end
    end
    in_valid = 1'b0;
    step();
    check("b2b_end", 32'(out_valid), 32'h0);

    // Backpressure
    out_ready = 1'b0;
    beat(1'b1, 8'h70, 8'h90);
    beat(1'b0, 8'h71, 8'h91);
    beat(1'b0, 8'h72, 8'h92);
    beat(1'b0, 8'h73, 8'h93);
    check("bp_f1_valid", 32'(out_valid), 32'h1);
    check("bp_f1_a",     out_a,          32'h73727170);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_first = (k == 0);
      in_a     = 8'(8'h80 + 8'(k));
      in_b     = 8'(8'hA0 + 8'(k));
      #1;
      check("bp_f2_ready", 32'(in_ready), 32'h1);
      step();
    end
    in_valid = 1'b1;
    in_first = 1'b0;
    in_a     = 8'h83;
    in_b     = 8'hA3;
    #1;
    check("bp_stall_ready", 32'(in_ready), 32'h0);
    step();
    step();
    check("bp_stall_ready2", 32'(in_ready),  32'h0);
    check("bp_hold_valid",   32'(out_valid), 32'h1);
    check("bp_hold_a",       out_a,          32'h73727170);
    check("bp_hold_b",       out_b,          32'h93929190);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    check("bp_f2_valid", 32'(out_valid), 32'h1);
    check("bp_f2_a",     out_a,          32'h83828180);
    check("bp_f2_b",     out_b,          32'hA3A2A1A0);
    step();
    check("bp_drain", 32'(out_valid), 32'h0);

    // Resync
    beat(1'b1, 8'hA0, 8'hC0);
    beat(1'b0, 8'hA1, 8'hC1);
    check("rs_err_pre", 32'(frame_err), 32'h0);
    beat(1'b1, 8'hB0, 8'hD0);
    check("rs_err",    32'(frame_err), 32'h1);
    check("rs_novalid", 32'(out_valid), 32'h0);
    beat(1'b0, 8'hB1, 8'hD1);
    check("rs_err_clr", 32'(frame_err), 32'h0);
    beat(1'b0, 8'hB2, 8'hD2);
    check("rs_novalid2", 32'(out_valid), 32'h0);
    beat(1'b0, 8'hB3, 8'hD3);
    check("rs_valid", 32'(out_valid), 32'h1);
    check("rs_a",     out_a,          32'hB3B2B1B0);
    check("rs_b",     out_b,          32'hD3D2D1D0);
    step();

    // Orphan beat followed by a clean frame
    beat(1'b0, 8'h55, 8'h66);
    check("or_err",     32'(frame_err), 32'h1);
    check("or_novalid", 32'(out_valid), 32'h0);
    beat(1'b1, 8'h60, 8'hE0);
    check("or_err_clr", 32'(frame_err), 32'h0);
    beat(1'b0, 8'h61, 8'hE1);
    beat(1'b0, 8'h62, 8'hE2);
    beat(1'b0, 8'h63, 8'hE3);
    check("or_valid", 32'(out_valid), 32'h1);
    check("or_a",     out_a,          32'h63626160);
    check("or_b",     out_b,          32'hE3E2E1E0);

    // Mid-frame reset while a frame is held
    out_ready = 1'b0;
    beat(1'b1, 8'h01, 8'h02);
    beat(1'b0, 8'h03, 8'h04);
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    check("mr_valid", 32'(out_valid), 32'h0);
    check("mr_a",     out_a,          32'h0);
    check("mr_b",     out_b,          32'h0);
    check("mr_ready", 32'(in_ready),  32'h1);
    beat(1'b1, 8'h20, 8'h30);
    beat(1'b0, 8'h21, 8'h31);
    beat(1'b0, 8'h22, 8'h32);
    check("mr_err", 32'(frame_err), 32'h0);
    beat(1'b0, 8'h23, 8'h33);
    check("mr_out_valid", 32'(out_valid), 32'h1);
    check("mr_out_a",     out_a,          32'h23222120);
    check("mr_out_b",     out_b,          32'h33323130);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
